// File: rtl/ahb_lite_eic_regs.sv
// ahb_lite_eic_regs: AHB-Lite slave register file for the eic core.
// Holds the STATUS word, per-channel mask and sense mode, and issues one-cycle
// forced set/clear strobes for the pending flags. Live flags are read back.
// Optional build macro EIC_AHB_ERROR_EN: unmapped offsets, the read-only IFR
// words and non-word transfers get a two-cycle AHB ERROR response.
// Assumes 32 < EIC_TOTAL_CHANNELS <= 64 and EIC_SENSE_CHANNELS <= 32.
module ahb_lite_eic_regs #(
   parameter int EIC_DIRECT_CHANNELS = 31,
   parameter int EIC_SENSE_CHANNELS  = 32,
   parameter int EIC_TOTAL_CHANNELS  = EIC_DIRECT_CHANNELS + EIC_SENSE_CHANNELS
) (
   input  logic                              CLK,
   input  logic                              RESETn,
   input  logic                              HSEL,
   input  logic [31:0]                       HADDR,
   input  logic [1:0]                        HTRANS,
   input  logic                              HWRITE,
   input  logic [2:0]                        HSIZE,
   input  logic [31:0]                       HWDATA,
   input  logic                              HREADY,
   output logic [31:0]                       HRDATA,
   output logic                              HREADYOUT,
   output logic                              HRESP,
   input  logic [EIC_TOTAL_CHANNELS-1:0]     request,
   output logic [EIC_TOTAL_CHANNELS-1:0]     mask,
   output logic [2*EIC_SENSE_CHANNELS-1:0]   senceMask,
   output logic [EIC_TOTAL_CHANNELS-1:0]     requestWR,
   output logic [EIC_TOTAL_CHANNELS-1:0]     requestIn,
   output logic [31:0]                       status
);

   localparam logic [3:0] A_STATUS  = 4'd0;
   localparam logic [3:0] A_MASK_L  = 4'd1;
   localparam logic [3:0] A_MASK_H  = 4'd2;
   localparam logic [3:0] A_IFR_L   = 4'd3;
   localparam logic [3:0] A_IFR_H   = 4'd4;
   localparam logic [3:0] A_IFRS_L  = 4'd5;
   localparam logic [3:0] A_IFRS_H  = 4'd6;
   localparam logic [3:0] A_IFRC_L  = 4'd7;
   localparam logic [3:0] A_IFRC_H  = 4'd8;
   localparam logic [3:0] A_SENSE_L = 4'd9;
   localparam logic [3:0] A_SENSE_H = 4'd10;

   logic                            accept;
   logic                            accept_ok;
   logic                            dph_valid;
   logic [3:0]                      dph_addr;
   logic                            dph_write;
   logic [2:0]                      dph_size;
   logic [31:0]                     status_next;
   logic [EIC_TOTAL_CHANNELS-1:0]   mask_next;
   logic [2*EIC_SENSE_CHANNELS-1:0] sense_next;
   logic [EIC_TOTAL_CHANNELS-1:0]   wr_pulse;
   logic [EIC_TOTAL_CHANNELS-1:0]   wr_value;
   logic [31:0]                     rd_data;
   logic                            unused_bits;

   assign accept      = HSEL & HREADY & HTRANS[1];
   assign unused_bits = ^{HADDR[31:6], HADDR[1:0], HTRANS[0], dph_size};

`ifdef EIC_AHB_ERROR_EN
   typedef enum logic [1:0] {ST_IDLE, ST_ERR1, ST_ERR2} err_state_t;

   err_state_t err_state;
   err_state_t err_state_next;
   logic       err_access;

   assign err_access = (HADDR[5:2] > A_SENSE_H) || (HADDR[5:2] == A_IFR_L) ||
                       (HADDR[5:2] == A_IFR_H) || (HSIZE != 3'b010);
   assign accept_ok  = accept & ~err_access;

   // Error response state register
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) err_state <= ST_IDLE;
      else         err_state <= err_state_next;
   end

   // Error sequencing: stall one cycle with ERROR, then complete ERROR
   always_comb begin
      err_state_next = err_state;
      HREADYOUT      = 1'b1;
      HRESP          = 1'b0;
      case (err_state)
         ST_IDLE: begin
            if (accept && err_access) err_state_next = ST_ERR1;
         end
         ST_ERR1: begin
            HREADYOUT      = 1'b0;
            HRESP          = 1'b1;
            err_state_next = ST_ERR2;
         end
         ST_ERR2: begin
            HRESP          = 1'b1;
            err_state_next = (accept && err_access) ? ST_ERR1 : ST_IDLE;
         end
         default: err_state_next = ST_IDLE;
      endcase
   end
`else
   assign accept_ok = accept;
   assign HREADYOUT = 1'b1;
   assign HRESP     = 1'b0;
`endif

   // Address phase capture; the valid flag lives for exactly one data phase
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         dph_valid <= 1'b0;
         dph_addr  <= 4'd0;
         dph_write <= 1'b0;
         dph_size  <= 3'd0;
      end else begin
         dph_valid <= accept_ok;
         if (accept) begin
            dph_addr  <= HADDR[5:2];
            dph_write <= HWRITE;
            dph_size  <= HSIZE;
         end
      end
   end

   // Next register values from the write finishing its data phase this cycle
   always_comb begin
      status_next = status;
      mask_next   = mask;
      sense_next  = senceMask;
      wr_pulse    = '0;
      wr_value    = '0;
      if (dph_valid && dph_write) begin
         if (dph_addr == A_STATUS) status_next = HWDATA;
         for (int i = 0; i < EIC_TOTAL_CHANNELS; i++) begin
            if (dph_addr == ((i < 32) ? A_MASK_L : A_MASK_H))
               mask_next[i] = HWDATA[i[4:0]];
            if (dph_addr == ((i < 32) ? A_IFRS_L : A_IFRS_H)) begin
               wr_pulse[i] = HWDATA[i[4:0]];
               wr_value[i] = HWDATA[i[4:0]];
            end
            if (dph_addr == ((i < 32) ? A_IFRC_L : A_IFRC_H))
               wr_pulse[i] = HWDATA[i[4:0]];
         end
         for (int i = 0; i < EIC_SENSE_CHANNELS; i++) begin
            if (dph_addr == ((i < 16) ? A_SENSE_L : A_SENSE_H))
               sense_next[2*i +: 2] = HWDATA[{i[3:0], 1'b0} +: 2];
         end
      end
   end

   // Read mux works on next values so a write just completing is forwarded
   always_comb begin
      rd_data = '0;
      if (HADDR[5:2] == A_STATUS) rd_data = status_next;
      for (int i = 0; i < EIC_TOTAL_CHANNELS; i++) begin
         if (HADDR[5:2] == ((i < 32) ? A_MASK_L : A_MASK_H))
            rd_data[i[4:0]] = mask_next[i];
         if (HADDR[5:2] == ((i < 32) ? A_IFR_L : A_IFR_H))
            rd_data[i[4:0]] = request[i];
      end
      for (int i = 0; i < EIC_SENSE_CHANNELS; i++) begin
         if (HADDR[5:2] == ((i < 16) ? A_SENSE_L : A_SENSE_H))
            rd_data[{i[3:0], 1'b0} +: 2] = sense_next[2*i +: 2];
      end
   end

   // Register file, one-cycle flag strobes and registered read data
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         status    <= '0;
         mask      <= '0;
         senceMask <= '1;
         requestWR <= '0;
         requestIn <= '0;
         HRDATA    <= '0;
      end else begin
         status    <= status_next;
         mask      <= mask_next;
         senceMask <= sense_next;
         requestWR <= wr_pulse;
         requestIn <= wr_value;
         if (accept_ok && !HWRITE) HRDATA <= rd_data;
      end
   end

endmodule

// File: tb/tb_ahb_lite_eic_regs.sv
// tb_ahb_lite_eic_regs: self-checking bench for ahb_lite_eic_regs.
// Directed table, hand sequences for pulses/forwarding/errors/reset, and a
// randomized pipelined run against a transaction-level register model.
// Honours EIC_AHB_ERROR_EN the same way as the design.
module tb_ahb_lite_eic_regs;

   localparam int          TOTAL = 63;
   localparam int          SENSE = 32;
   localparam logic [31:0] BASE  = 32'h1F80_0000;
   localparam int          NRAND = 400;

   logic              CLK = 1'b0;
   logic              RESETn;
   logic              HSEL;
   logic [31:0]       HADDR;
   logic [1:0]        HTRANS;
   logic              HWRITE;
   logic [2:0]        HSIZE;
   logic [31:0]       HWDATA;
   logic              HREADY;
   logic [31:0]       HRDATA;
   logic              HREADYOUT;
   logic              HRESP;
   logic [TOTAL-1:0]  request;
   logic [TOTAL-1:0]  mask;
   logic [2*SENSE-1:0] senceMask;
   logic [TOTAL-1:0]  requestWR;
   logic [TOTAL-1:0]  requestIn;
   logic [31:0]       status;

   int checks = 0;
   int errors = 0;

   ahb_lite_eic_regs dut (
      .CLK(CLK), .RESETn(RESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
      .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .request(request),
      .mask(mask), .senceMask(senceMask), .requestWR(requestWR),
      .requestIn(requestIn), .status(status)
   );

   // Clock generation
   always #5 CLK = ~CLK;

   // Single slave on the bus: HREADY follows our own HREADYOUT
   assign HREADY = HREADYOUT;

   // Stand-in for the eic flag store: forced writes land one cycle later
   always @(posedge CLK or negedge RESETn) begin
      if (!RESETn) request <= '0;
      else for (int i = 0; i < TOTAL; i++) if (requestWR[i]) request[i] <= requestIn[i];
   end

   // Watchdog so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // ---------------- reference model ----------------
   typedef struct { int slot; bit set; bit hi; logic [31:0] data; } pend_t;

   logic [31:0] m_status;
   bit          m_mask  [TOTAL];
   logic [1:0]  m_sense [SENSE];
   bit          m_flags [TOTAL];
   pend_t       pend[$];

   function automatic void modelReset();
      m_status = '0;
      for (int c = 0; c < TOTAL; c++) begin m_mask[c] = 1'b0; m_flags[c] = 1'b0; end
      for (int c = 0; c < SENSE; c++) m_sense[c] = 2'b11;
      pend.delete();
   endfunction

   function automatic void modelWrite(input logic [3:0] idx, input logic [31:0] d, input int slot);
      pend_t p;
      case (idx)
         4'd0: m_status = d;
         4'd1, 4'd2: for (int j = 0; j < 32; j++)
                        if (32*(idx-1) + j < TOTAL) m_mask[32*(idx-1) + j] = d[j];
         4'd5, 4'd6, 4'd7, 4'd8: begin
            p.slot = slot; p.set = (idx <= 4'd6); p.hi = (idx == 4'd6 || idx == 4'd8); p.data = d;
            pend.push_back(p);
         end
         4'd9, 4'd10: for (int c = 0; c < 16; c++) m_sense[16*(idx-9) + c] = d[2*c +: 2];
         default: ;
      endcase
   endfunction

   // Forced flags reach the IFR readback three address slots after the write slot
   function automatic void modelAdvance(input int now);
      while (pend.size() > 0 && pend[0].slot <= now - 3) begin
         for (int j = 0; j < 32; j++) begin
            int ch = pend[0].hi ? 32 + j : j;
            if (ch < TOTAL && pend[0].data[j]) m_flags[ch] = pend[0].set;
         end
         void'(pend.pop_front());
      end
   endfunction

   function automatic logic [31:0] modelRead(input logic [3:0] idx);
      logic [31:0] r = '0;
      case (idx)
         4'd0: r = m_status;
         4'd1, 4'd2: for (int j = 0; j < 32; j++)
                        if (32*(idx-1) + j < TOTAL) r[j] = m_mask[32*(idx-1) + j];
         4'd3, 4'd4: for (int j = 0; j < 32; j++)
                        if (32*(idx-3) + j < TOTAL) r[j] = m_flags[32*(idx-3) + j];
         4'd9, 4'd10: for (int c = 0; c < 16; c++) r[2*c +: 2] = m_sense[16*(idx-9) + c];
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic logic [63:0] modelMask();
      logic [63:0] v = '0;
      for (int c = 0; c < TOTAL; c++) v[c] = m_mask[c];
      return v;
   endfunction

   function automatic logic [63:0] modelSense();
      logic [63:0] v = '0;
      for (int c = 0; c < SENSE; c++) v[2*c +: 2] = m_sense[c];
      return v;
   endfunction

   // Strobe vector a write to IFRS/IFRC word idx must produce
   function automatic logic [63:0] expPulse(input logic [3:0] idx, input logic [31:0] d);
      logic [63:0] v = '0;
      if (idx == 4'd5 || idx == 4'd7) v[31:0] = d;
      if (idx == 4'd6 || idx == 4'd8) v[62:32] = d[30:0];
      return v;
   endfunction

   function automatic bit illegalIdx(input logic [3:0] idx);
`ifdef EIC_AHB_ERROR_EN
      return (idx == 4'd3 || idx == 4'd4 || idx > 4'd10);
`else
      return (idx == 4'hF && 1'b0);
`endif
   endfunction

   // ---------------- tasks ----------------
   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic busIdle();
      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'b010; HADDR = BASE;
   endtask

   // One non-pipelined transfer; returns just after the data phase ends
   task automatic applyStimulus(input bit wr, input logic [7:0] off, input logic [31:0] wdata,
                                output logic [31:0] rdata);
      HSEL = 1'b1; HTRANS = 2'b10; HADDR = BASE | {24'h0, off}; HWRITE = wr; HSIZE = 3'b010;
      HWDATA = '0;
      @(posedge CLK); #1;
      rdata = HRDATA;
      busIdle();
      HWDATA = wdata;
      @(posedge CLK); #1;
   endtask

   typedef struct { bit write; logic [7:0] off; logic [31:0] wdata; logic [31:0] exp_rd; logic [31:0] exp_mask_l; } vec_t;

   function automatic vec_t mk(input bit w, input logic [7:0] o, input logic [31:0] d,
                               input logic [31:0] er, input logic [31:0] em);
      vec_t v;
      v.write = w; v.off = o; v.wdata = d; v.exp_rd = er; v.exp_mask_l = em;
      return v;
   endfunction

   typedef struct { bit valid; bit write; logic [3:0] idx; logic [31:0] data; } txn_t;

   // ---------------- test sequence ----------------
   initial begin
      vec_t        tbl[$];
      logic [31:0] rd;
      txn_t        cur, prev;
      logic [63:0] ep;

      RESETn = 1'b0; HWDATA = '0; busIdle();
      repeat (3) @(posedge CLK);
      #1 RESETn = 1'b1;
      @(posedge CLK); #1;

      $display("[TB] reset values");
      checkOutput("rst_hreadyout", {63'b0, HREADYOUT}, 64'd1);
      checkOutput("rst_hresp", {63'b0, HRESP}, 64'd0);
      checkOutput("rst_hrdata", {32'b0, HRDATA}, 64'd0);
      checkOutput("rst_mask", {1'b0, mask}, 64'd0);
      checkOutput("rst_sense", senceMask, 64'hFFFF_FFFF_FFFF_FFFF);
      checkOutput("rst_status", {32'b0, status}, 64'd0);
      checkOutput("rst_requestWR", {1'b0, requestWR}, 64'd0);
      checkOutput("rst_requestIn", {1'b0, requestIn}, 64'd0);

      $display("[TB] directed table");
      tbl.push_back(mk(1'b0, 8'h04, 32'h0,          32'h0000_0000, 32'h0));
      tbl.push_back(mk(1'b0, 8'h24, 32'h0,          32'hFFFF_FFFF, 32'h0));
      tbl.push_back(mk(1'b0, 8'h28, 32'h0,          32'hFFFF_FFFF, 32'h0));
      tbl.push_back(mk(1'b0, 8'h00, 32'h0,          32'h0000_0000, 32'h0));
      tbl.push_back(mk(1'b0, 8'h08, 32'h0,          32'h0000_0000, 32'h0));
      tbl.push_back(mk(1'b1, 8'h04, 32'h0000_00A5,  32'h0,         32'hA5));
      tbl.push_back(mk(1'b0, 8'h04, 32'h0,          32'h0000_00A5, 32'hA5));
      tbl.push_back(mk(1'b1, 8'h08, 32'hFFFF_FFFF,  32'h0,         32'hA5));
      tbl.push_back(mk(1'b0, 8'h08, 32'h0,          32'h7FFF_FFFF, 32'hA5));
      tbl.push_back(mk(1'b1, 8'h00, 32'hDEAD_BEEF,  32'h0,         32'hA5));
      tbl.push_back(mk(1'b0, 8'h00, 32'h0,          32'hDEAD_BEEF, 32'hA5));
      tbl.push_back(mk(1'b1, 8'h28, 32'h0000_0004,  32'h0,         32'hA5));
      tbl.push_back(mk(1'b0, 8'h28, 32'h0,          32'h0000_0004, 32'hA5));
      tbl.push_back(mk(1'b0, 8'h24, 32'h0,          32'hFFFF_FFFF, 32'hA5));
      tbl.push_back(mk(1'b0, 8'h14, 32'h0,          32'h0000_0000, 32'hA5));
      tbl.push_back(mk(1'b0, 8'h20, 32'h0,          32'h0000_0000, 32'hA5));
      for (int i = 0; i < tbl.size(); i++) begin
         applyStimulus(tbl[i].write, tbl[i].off, tbl[i].wdata, rd);
         if (!tbl[i].write) checkOutput($sformatf("tbl%0d_rdata", i), {32'b0, rd}, {32'b0, tbl[i].exp_rd});
         checkOutput($sformatf("tbl%0d_mask_l", i), {32'b0, mask[31:0]}, {32'b0, tbl[i].exp_mask_l});
      end
      checkOutput("tbl_mask_full", {1'b0, mask}, 64'h7FFF_FFFF_0000_00A5);
      checkOutput("tbl_sense_full", senceMask, 64'h0000_0004_FFFF_FFFF);
      checkOutput("tbl_status", {32'b0, status}, 64'hDEAD_BEEF);

      $display("[TB] IFRS_L single pulse");
      applyStimulus(1'b1, 8'h14, 32'h0000_0011, rd);
      checkOutput("ifrs_wr_pulse", {1'b0, requestWR}, 64'h11);
      checkOutput("ifrs_in_pulse", {1'b0, requestIn} & 64'h11, 64'h11);
      @(posedge CLK); #1;
      checkOutput("ifrs_wr_after", {1'b0, requestWR}, 64'h0);
      checkOutput("ifrs_in_after", {1'b0, requestIn}, 64'h0);
`ifndef EIC_AHB_ERROR_EN
      applyStimulus(1'b0, 8'h0C, 32'h0, rd);
      checkOutput("ifr_l_after_set", {32'b0, rd}, 64'h11);
`endif

      $display("[TB] back-to-back IFRS_H / IFRC_L");
      HSEL = 1'b1; HTRANS = 2'b10; HADDR = BASE | 32'h18; HWRITE = 1'b1; HSIZE = 3'b010;
      @(posedge CLK); #1;
      HADDR = BASE | 32'h1C; HWDATA = 32'h1;
      @(posedge CLK); #1;
      busIdle(); HWDATA = 32'h10;
      checkOutput("b2b_pulse1_wr", {1'b0, requestWR}, 64'h1_0000_0000);
      checkOutput("b2b_pulse1_in", {1'b0, requestIn} & 64'h1_0000_0000, 64'h1_0000_0000);
      @(posedge CLK); #1;
      checkOutput("b2b_pulse2_wr", {1'b0, requestWR}, 64'h10);
      checkOutput("b2b_pulse2_in", {1'b0, requestIn} & 64'h10, 64'h0);
      @(posedge CLK); #1;
      checkOutput("b2b_idle_wr", {1'b0, requestWR}, 64'h0);
`ifndef EIC_AHB_ERROR_EN
      applyStimulus(1'b0, 8'h0C, 32'h0, rd);
      checkOutput("b2b_ifr_l", {32'b0, rd}, 64'h01);
      applyStimulus(1'b0, 8'h10, 32'h0, rd);
      checkOutput("b2b_ifr_h", {32'b0, rd}, 64'h01);

      $display("[TB] unmapped offset completes OKAY");
      HSEL = 1'b1; HTRANS = 2'b10; HADDR = BASE | 32'h30; HWRITE = 1'b1; HSIZE = 3'b010;
      @(posedge CLK); #1;
      busIdle(); HWDATA = 32'h1234_5678;
      checkOutput("unmap_hreadyout", {63'b0, HREADYOUT}, 64'd1);
      checkOutput("unmap_hresp", {63'b0, HRESP}, 64'd0);
      @(posedge CLK); #1;
      applyStimulus(1'b0, 8'h30, 32'h0, rd);
      checkOutput("unmap_rdata", {32'b0, rd}, 64'h0);
      checkOutput("unmap_status", {32'b0, status}, 64'hDEAD_BEEF);
`else
      $display("[TB] ERROR responses");
      HSEL = 1'b1; HTRANS = 2'b10; HADDR = BASE | 32'h30; HWRITE = 1'b1; HSIZE = 3'b010;
      @(posedge CLK); #1;
      busIdle(); HWDATA = 32'h1234_5678;
      checkOutput("err1_hreadyout", {63'b0, HREADYOUT}, 64'd0);
      checkOutput("err1_hresp", {63'b0, HRESP}, 64'd1);
      @(posedge CLK); #1;
      checkOutput("err2_hreadyout", {63'b0, HREADYOUT}, 64'd1);
      checkOutput("err2_hresp", {63'b0, HRESP}, 64'd1);
      @(posedge CLK); #1;
      checkOutput("err_done_hresp", {63'b0, HRESP}, 64'd0);
      checkOutput("err_status", {32'b0, status}, 64'hDEAD_BEEF);
      HSEL = 1'b1; HTRANS = 2'b10; HADDR = BASE | 32'h04; HWRITE = 1'b1; HSIZE = 3'b000;
      @(posedge CLK); #1;
      busIdle(); HWDATA = 32'h0000_00FF;
      checkOutput("errsz_hreadyout", {63'b0, HREADYOUT}, 64'd0);
      @(posedge CLK); #1;
      HSEL = 1'b1; HTRANS = 2'b10; HADDR = BASE | 32'h04; HWRITE = 1'b0; HSIZE = 3'b010;
      checkOutput("errsz_requestWR", {1'b0, requestWR}, 64'h0);
      @(posedge CLK); #1;
      busIdle();
      checkOutput("err2_accept_hresp", {63'b0, HRESP}, 64'd0);
      checkOutput("err2_accept_rdata", {32'b0, HRDATA}, 64'hA5);
      checkOutput("errsz_mask_l", {32'b0, mask[31:0]}, 64'hA5);
      @(posedge CLK); #1;
`endif

      $display("[TB] write forwarded into next read");
      HSEL = 1'b1; HTRANS = 2'b10; HADDR = BASE | 32'h04; HWRITE = 1'b1; HSIZE = 3'b010;
      @(posedge CLK); #1;
      HWRITE = 1'b0; HWDATA = 32'h0000_5A5A;
      @(posedge CLK); #1;
      busIdle();
      checkOutput("fwd_rdata", {32'b0, HRDATA}, 64'h5A5A);
      checkOutput("fwd_mask_l", {32'b0, mask[31:0]}, 64'h5A5A);
      @(posedge CLK); #1;

      $display("[TB] reset during data phase");
      HSEL = 1'b1; HTRANS = 2'b10; HADDR = BASE | 32'h14; HWRITE = 1'b1; HSIZE = 3'b010;
      @(posedge CLK); #1;
      busIdle(); HWDATA = 32'hFFFF_FFFF;
      #2 RESETn = 1'b0;
      @(posedge CLK); #1;
      checkOutput("rstmid_requestWR", {1'b0, requestWR}, 64'h0);
      RESETn = 1'b1;
      @(posedge CLK); #1;
      checkOutput("rstmid_requestWR2", {1'b0, requestWR}, 64'h0);
      checkOutput("rstmid_mask", {1'b0, mask}, 64'h0);
      checkOutput("rstmid_flags", {1'b0, request}, 64'h0);

      $display("[TB] randomized pipelined traffic");
      modelReset();
      prev.valid = 1'b0; prev.write = 1'b0; prev.idx = '0; prev.data = '0;
      for (int t = 0; t <= NRAND; t++) begin
         cur.valid = (t < NRAND) && ($urandom_range(0, 9) != 0);
         cur.write = 1'($urandom_range(0, 1));
         do cur.idx = 4'($urandom_range(0, 15)); while (illegalIdx(cur.idx));
         cur.data = $urandom;
         HSEL   = cur.valid;
         HTRANS = cur.valid ? 2'b10 : 2'b00;
         HADDR  = BASE | {26'h0, cur.idx, 2'b00};
         HWRITE = cur.write;
         HSIZE  = 3'b010;
         HWDATA = (prev.valid && prev.write) ? prev.data : $urandom;
         @(posedge CLK); #1;
         ep = '0;
         if (prev.valid && prev.write) begin
            modelWrite(prev.idx, prev.data, t - 1);
            ep = expPulse(prev.idx, prev.data);
         end
         modelAdvance(t);
         checkOutput("rand_mask", {1'b0, mask}, modelMask());
         checkOutput("rand_sense", senceMask, modelSense());
         checkOutput("rand_status", {32'b0, status}, {32'b0, m_status});
         checkOutput("rand_requestWR", {1'b0, requestWR}, ep);
         checkOutput("rand_requestIn", {1'b0, requestIn} & ep,
                     (prev.idx == 4'd5 || prev.idx == 4'd6) ? ep : 64'h0);
         if (cur.valid && !cur.write)
            checkOutput($sformatf("rand_rdata_idx%0d", cur.idx), {32'b0, HRDATA}, {32'b0, modelRead(cur.idx)});
         prev = cur;
      end
      busIdle();
      @(posedge CLK); #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
